// File: rtl/cache_pkg.sv
// Shared constants and FSM state encoding for the cache line-fill controller.
package cache_pkg;

   localparam int unsigned DATA_WIDTH  = 8;
   localparam int unsigned ADDR_BITS   = 15;
   localparam int unsigned OFFSET_BITS = 5;
   localparam int unsigned BANK_BITS   = 2;
   localparam int unsigned LINE_BYTES  = 32;
   localparam int unsigned NUM_BANKS   = 4;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } fill_state_e;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// External SRAM read port of the fill controller: request/address out, ack/data back.
interface cache_fill_ctrl_if #(
   parameter int unsigned ADDR_BITS  = 15,
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic                  sram_rd_o;
   logic [ADDR_BITS-1:0]  sram_addr_o;
   logic                  sram_ack_i;
   logic [DATA_WIDTH-1:0] sram_data_i;

   modport master (
      output sram_rd_o,
      output sram_addr_o,
      input  sram_ack_i,
      input  sram_data_i
   );

   modport slave (
      input  sram_rd_o,
      input  sram_addr_o,
      output sram_ack_i,
      output sram_data_i
   );

endinterface

// File: rtl/cache_fill_fsm.sv
// Fill sequencer: state register, byte offset counter and ack watchdog.
// Build macro CACHE_FILL_TIMEOUT_EN enables the watchdog abort out of READ.
module cache_fill_fsm #(
   parameter int unsigned OFFSET_BITS    = 5,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    fill_req,
   input  logic                    ack,
   output cache_pkg::fill_state_e  state_q,
   output cache_pkg::fill_state_e  state_d,
   output logic [OFFSET_BITS-1:0]  offset_q,
   output logic [OFFSET_BITS-1:0]  offset_d,
   output logic                    timeout
);

   import cache_pkg::*;

   logic wd_expired;

`ifdef CACHE_FILL_TIMEOUT_EN
   logic [7:0] wait_q;

   // Held at zero outside READ, so every entry into READ starts a fresh count.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         wait_q <= '0;
      end else if (state_q != READ) begin
         wait_q <= '0;
      end else if (!ack) begin
         wait_q <= wait_q + 8'd1;
      end
   end

   assign wd_expired = (wait_q == 8'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign wd_expired         = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= IDLE;
         offset_q <= '0;
      end else begin
         state_q  <= state_d;
         offset_q <= offset_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      offset_d = offset_q;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (fill_req) begin
               state_d  = READ;
               offset_d = '0;
            end
         end
         READ: begin
            if (ack) begin
               state_d = WRITE;
            end else if (wd_expired) begin
               state_d = IDLE;
               timeout = 1'b1;
            end
         end
         WRITE: begin
            if (offset_q == '1) begin
               state_d = DONE;
            end else begin
               state_d  = READ;
               offset_d = offset_q + OFFSET_BITS'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller: copies one 32-byte line from SRAM into a cache bank.
// Build macro CACHE_FILL_TIMEOUT_EN enables the SRAM ack watchdog (fill_err_o).
module cache_fill_ctrl #(
   parameter int unsigned DATA_WIDTH     = cache_pkg::DATA_WIDTH,
   parameter int unsigned ADDR_BITS      = cache_pkg::ADDR_BITS,
   parameter int unsigned OFFSET_BITS    = cache_pkg::OFFSET_BITS,
   parameter int unsigned BANK_BITS      = cache_pkg::BANK_BITS,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              fill_req_i,
   input  logic [ADDR_BITS-OFFSET_BITS-1:0]  fill_line_i,
   output logic                              fill_busy_o,
   output logic                              fill_done_o,
   output logic                              fill_err_o,
   output logic [(2**BANK_BITS)-1:0]         bank_valid_o,
   cache_fill_ctrl_if.master                 sram,
   output logic [OFFSET_BITS-1:0]            write_address,
   output logic [DATA_WIDTH-1:0]             write_data,
   output logic [BANK_BITS-1:0]              bank_i_select,
   output logic                              bank_enable
);

   import cache_pkg::*;

   localparam int unsigned LINE_BITS = ADDR_BITS - OFFSET_BITS;

   fill_state_e            state_q;
   fill_state_e            state_d;
   logic [OFFSET_BITS-1:0] offset_q;
   logic [OFFSET_BITS-1:0] offset_d;
   logic                   timeout;
   logic [LINE_BITS-1:0]   line_q;
   logic                   start;
   logic                   take;

   cache_fill_fsm #(
      .OFFSET_BITS    (OFFSET_BITS),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_fsm (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .fill_req (fill_req_i),
      .ack      (sram.sram_ack_i),
      .state_q  (state_q),
      .state_d  (state_d),
      .offset_q (offset_q),
      .offset_d (offset_d),
      .timeout  (timeout)
   );

   assign start = (state_q == IDLE) && fill_req_i;
   assign take  = (state_q == READ) && sram.sram_ack_i;

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         fill_busy_o      <= 1'b0;
         fill_done_o      <= 1'b0;
         fill_err_o       <= 1'b0;
         bank_valid_o     <= '0;
         sram.sram_rd_o   <= 1'b0;
         sram.sram_addr_o <= '0;
         write_address    <= '0;
         write_data       <= '0;
         bank_i_select    <= '0;
         bank_enable      <= 1'b0;
         line_q           <= '0;
      end else begin
         fill_busy_o    <= (state_d != IDLE);
         fill_done_o    <= (state_d == DONE);
         fill_err_o     <= timeout;
         sram.sram_rd_o <= (state_d == READ);
         bank_enable    <= take;

         if (start) begin
            line_q                                  <= fill_line_i;
            bank_i_select                           <= fill_line_i[BANK_BITS-1:0];
            bank_valid_o[fill_line_i[BANK_BITS-1:0]] <= 1'b0;
            sram.sram_addr_o                        <= {fill_line_i, offset_d};
         end else if (state_d == READ) begin
            sram.sram_addr_o <= {line_q, offset_d};
         end

         if (state_d == DONE) begin
            bank_valid_o[bank_i_select] <= 1'b1;
         end

         if (take) begin
            write_data    <= sram.sram_data_i;
            write_address <= offset_q;
         end
      end
   end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed testbench for cache_fill_ctrl with an address-derived SRAM data model.
module tb_cache_fill_ctrl;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       fill_req_i;
   logic [9:0] fill_line_i;
   logic       fill_busy_o;
   logic       fill_done_o;
   logic       fill_err_o;
   logic [3:0] bank_valid_o;
   logic [4:0] write_address;
   logic [7:0] write_data;
   logic [1:0] bank_i_select;
   logic       bank_enable;

   int checks   = 0;
   int failures = 0;

   cache_fill_ctrl_if #(.ADDR_BITS(15), .DATA_WIDTH(8)) sram ();

   cache_fill_ctrl #(
      .DATA_WIDTH     (8),
      .ADDR_BITS      (15),
      .OFFSET_BITS    (5),
      .BANK_BITS      (2),
      .TIMEOUT_CYCLES (255)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .fill_req_i    (fill_req_i),
      .fill_line_i   (fill_line_i),
      .fill_busy_o   (fill_busy_o),
      .fill_done_o   (fill_done_o),
      .fill_err_o    (fill_err_o),
      .bank_valid_o  (bank_valid_o),
      .sram          (sram),
      .write_address (write_address),
      .write_data    (write_data),
      .bank_i_select (bank_i_select),
      .bank_enable   (bank_enable)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [7:0] model(input logic [14:0] a);
      return a[7:0] ^ 8'(a[14:8]) ^ 8'hA5;
   endfunction

   assign sram.sram_data_i = model(sram.sram_addr_o);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // n counts cycles after the request-sampling edge (n=1 is the first READ cycle).
   // delay<0 picks a random 0-7 ack delay per byte; req_at/rst_at<0 disable those events.
   task automatic run_fill(input logic [9:0] line, input int delay, input int req_at,
                           input int rst_at, input int exp_cycles, input logic [3:0] exp_valid);
      int n, wr, waited, dly;
      logic done_seen;
      logic [3:0] mid_valid;
      logic [1:0] bk;
      bk        = line[1:0];
      mid_valid = bank_valid_o & ~(4'b0001 << bk);
      dly       = (delay < 0) ? int'($urandom_range(7, 0)) : delay;
      n = 0; wr = 0; waited = 0; done_seen = 1'b0;
      @(negedge clk_i);
      fill_req_i  = 1'b1;
      fill_line_i = line;
      @(posedge clk_i);
      while (!done_seen && n < 3000) begin
         @(negedge clk_i);
         n++;
         fill_req_i = (n == req_at);
         if (n == req_at) fill_line_i = ~line;
         chk("busy_in_fill", 64'(fill_busy_o), 64'(1));
         chk("err_in_fill", 64'(fill_err_o), 64'(0));
         if (sram.sram_rd_o) begin
            chk("sram_addr", 64'(sram.sram_addr_o), 64'({line, 5'(wr)}));
            chk("enable_in_read", 64'(bank_enable), 64'(0));
         end
         if (bank_enable) begin
            chk("write_address", 64'(write_address), 64'(wr));
            chk("write_data", 64'(write_data), 64'(model({line, 5'(wr)})));
            chk("bank_select", 64'(bank_i_select), 64'(bk));
            wr++;
         end
         if (fill_done_o) begin
            done_seen = 1'b1;
            if (exp_cycles >= 0) chk("done_latency", 64'(n), 64'(exp_cycles));
            chk("write_count", 64'(wr), 64'(32));
            chk("valid_at_done", 64'(bank_valid_o), 64'(exp_valid));
         end else begin
            chk("valid_in_fill", 64'(bank_valid_o), 64'(mid_valid));
         end
         if (rst_at >= 0 && sram.sram_rd_o && wr == rst_at) begin
            reset_i = 1'b0;
            @(negedge clk_i);
            chk("abort_ctrl", 64'({fill_busy_o, fill_done_o, fill_err_o, bank_valid_o,
                                   sram.sram_rd_o, bank_enable}), 64'(0));
            chk("abort_data", 64'({sram.sram_addr_o, write_address, write_data, bank_i_select}),
                64'(0));
            reset_i = 1'b1;
            repeat (3) begin
               @(negedge clk_i);
               chk("abort_quiet", 64'({fill_busy_o, bank_enable, sram.sram_rd_o}), 64'(0));
            end
            return;
         end
         // Ack is held high outside READ; the controller must ignore it there.
         if (sram.sram_rd_o) begin
            if (waited >= dly) begin
               sram.sram_ack_i = 1'b1;
               waited          = 0;
               if (delay < 0) dly = int'($urandom_range(7, 0));
            end else begin
               sram.sram_ack_i = 1'b0;
               waited++;
            end
         end else begin
            sram.sram_ack_i = 1'b1;
         end
      end
      chk("done_seen", 64'(done_seen), 64'(1));
      @(negedge clk_i);
      chk("done_pulse_width", 64'(fill_done_o), 64'(0));
      chk("busy_after_fill", 64'(fill_busy_o), 64'(0));
      chk("valid_after_fill", 64'(bank_valid_o), 64'(exp_valid));
      if (req_at >= 0) begin
         repeat (8) begin
            @(negedge clk_i);
            chk("no_second_fill", 64'({fill_busy_o, bank_enable, fill_done_o}), 64'(0));
         end
      end
   endtask

`ifdef CACHE_FILL_TIMEOUT_EN
   task automatic run_timeout(input logic [9:0] line, input logic [3:0] exp_valid);
      int n, wr, cnt;
      logic err_seen;
      n = 0; wr = 0; cnt = 0; err_seen = 1'b0;
      @(negedge clk_i);
      fill_req_i  = 1'b1;
      fill_line_i = line;
      @(posedge clk_i);
      while (!err_seen && n < 2000) begin
         @(negedge clk_i);
         n++;
         fill_req_i = 1'b0;
         chk("to_no_done", 64'(fill_done_o), 64'(0));
         if (bank_enable) wr++;
         if (fill_err_o) begin
            err_seen = 1'b1;
            chk("to_wait_cycles", 64'(cnt), 64'(255));
            chk("to_rd_dropped", 64'(sram.sram_rd_o), 64'(0));
            chk("to_idle", 64'(fill_busy_o), 64'(0));
            chk("to_valid", 64'(bank_valid_o), 64'(exp_valid));
         end
         if (sram.sram_rd_o && wr == 3) begin
            cnt++;
            sram.sram_ack_i = 1'b0;
         end else begin
            sram.sram_ack_i = 1'b1;
         end
      end
      chk("to_err_seen", 64'(err_seen), 64'(1));
      @(negedge clk_i);
      chk("to_err_pulse", 64'(fill_err_o), 64'(0));
      chk("to_writes", 64'(wr), 64'(3));
      chk("to_valid_after", 64'(bank_valid_o), 64'(exp_valid));
   endtask
`endif

   typedef struct {
      logic [9:0] line;
      int         delay;
      int         exp_cycles;
      logic [3:0] exp_valid;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{10'h005, 0, 65,  4'b0010};
      vecs[1] = '{10'h3FF, 2, 129, 4'b1010};
      vecs[2] = '{10'h002, 1, 97,  4'b1110};
      vecs[3] = '{10'h000, 0, 65,  4'b1111};

      // Request and ack are asserted during reset; neither may have any effect.
      reset_i         = 1'b0;
      fill_req_i      = 1'b1;
      fill_line_i     = 10'h155;
      sram.sram_ack_i = 1'b1;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("reset_ctrl", 64'({fill_busy_o, fill_done_o, fill_err_o, bank_valid_o,
                             sram.sram_rd_o, bank_enable}), 64'(0));
      chk("reset_data", 64'({sram.sram_addr_o, write_address, write_data, bank_i_select}), 64'(0));
      fill_req_i = 1'b0;
      reset_i    = 1'b1;
      @(negedge clk_i);
      chk("idle_after_reset", 64'(fill_busy_o), 64'(0));

      for (int i = 0; i < 4; i++) begin
         run_fill(vecs[i].line, vecs[i].delay, -1, -1, vecs[i].exp_cycles, vecs[i].exp_valid);
      end

      run_fill(10'h3FF, -1, -1, -1, -1, 4'b1111);
      run_fill(10'h1A1, 0, -1, -1, 65, 4'b1111);
      run_fill(10'h0C2, 0, 20, -1, 65, 4'b1111);
      run_fill(10'h0E6, 0, -1, 10, -1, 4'b0000);
      run_fill(10'h005, 0, -1, -1, 65, 4'b0010);
`ifdef CACHE_FILL_TIMEOUT_EN
      run_timeout(10'h003, 4'b0010);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete in time");
      $fatal(1, "global timeout");
   end

endmodule
